// File: rtl/instr_fetch_stage_pkg.sv
// instr_fetch_stage_pkg: shared FSM encoding, widths and constants for the fetch stage
package instr_fetch_stage_pkg;
    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} fetch_state_e;
    function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold (stall) and invalidate (flush)
module if_id_reg
    import instr_fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [INSTR_W-1:0] i_pc4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [INSTR_W-1:0] o_pc4,
    output logic               o_valid
);
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] r_pc4;
    logic               r_valid;
    // flush beats stall; stall holds; an unstalled cycle without a load becomes a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_valid <= i_load;
            if (i_load) begin
                r_instr <= i_instr;
                r_pc4   <= i_pc4;
            end
        end
    end
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, imem request FSM, pending buffer and IF/ID register.
// Define IFETCH_PERF_EN to add the fetch_count performance counter output.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [INSTR_W-1:0]  branch_target,
    input  logic                jump,
    input  logic [INSTR_W-1:0]  jump_target,
    output logic                imem_req,
    output logic [INSTR_W-1:0]  imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [INSTR_W-1:0]  if_id_pc4,
    output logic                if_id_valid,
    output logic [OPCODE_W-1:0] opcode
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]         fetch_count
`endif
);
    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] r_drain_addr;
    logic [INSTR_W-1:0] r_pend_instr;
    logic [INSTR_W-1:0] r_pend_pc4;
    logic [INSTR_W-1:0] w_next_pc;
    logic [INSTR_W-1:0] w_pc4;
    logic [INSTR_W-1:0] w_target;
    logic [INSTR_W-1:0] w_load_instr;
    logic [INSTR_W-1:0] w_load_pc4;
    logic               w_redirect;
    logic               w_load;
    logic               w_pend_wr;
    logic               w_drain_wr;

    assign w_pc4      = pc_plus4(r_pc);
    assign w_redirect = jump | branch_taken;
    assign w_target   = jump ? jump_target : branch_target;
    assign imem_req   = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr  = (r_state == DRAIN) ? r_drain_addr : r_pc;
    assign opcode     = if_id_instr[INSTR_W-1 -: OPCODE_W];

    // next state, next pc and IF/ID load selection; a redirect always wins over a load
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_load       = 1'b0;
        w_load_instr = imem_rdata;
        w_load_pc4   = w_pc4;
        w_pend_wr    = 1'b0;
        w_drain_wr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
                if (w_redirect) w_next_pc = w_target;
            end
            FETCH: begin
                if (w_redirect) begin
                    w_next_pc    = w_target;
                    w_next_state = imem_ack ? FETCH : DRAIN;
                    w_drain_wr   = !imem_ack;
                end else if (imem_ack) begin
                    w_next_pc    = w_pc4;
                    w_load       = !stall;
                    w_pend_wr    = stall;
                    w_next_state = stall ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_next_pc    = w_target;
                    w_next_state = FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_pend_instr;
                    w_load_pc4   = r_pend_pc4;
                    w_next_state = FETCH;
                end
            end
            DRAIN: begin
                if (w_redirect) w_next_pc = w_target;
                if (imem_ack) w_next_state = FETCH;
            end
        endcase
    end

    // state, pc, drained-request address and pending buffer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_pend_instr <= NOP;
            r_pend_pc4   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_drain_wr) r_drain_addr <= r_pc;
            if (w_pend_wr) begin
                r_pend_instr <= imem_rdata;
                r_pend_pc4   <= w_pc4;
            end
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_stall (stall),
        .i_flush (w_redirect),
        .i_load  (w_load),
        .i_instr (w_load_instr),
        .i_pc4   (w_load_pc4),
        .o_instr (if_id_instr),
        .o_pc4   (if_id_pc4),
        .o_valid (if_id_valid)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] r_fetch_count;
    // count every valid word loaded into IF/ID
    always_ff @(posedge clk) begin
        if (!rst_n) r_fetch_count <= '0;
        else if (w_load) r_fetch_count <= r_fetch_count + 32'd1;
    end
    assign fetch_count = r_fetch_count;
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed vector table, reset sequence and randomized stream check
module tb_instr_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .opcode        (opcode)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, ak, br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid, chk;
        logic [31:0] e_instr, e_pc4;
    } vec_t;

    vec_t vec[24];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h8C01_0004 ^ {a[23:0], 8'h00};
    endfunction

    function automatic vec_t mk(input logic st, ak, br, input logic [31:0] bt, input logic jp,
                                input logic [31:0] jt, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, chk, input logic [31:0] e_instr, e_pc4);
        vec_t v;
        v.st = st; v.ak = ak; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.chk = chk;
        v.e_instr = e_instr; v.e_pc4 = e_pc4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, ak, br, input logic [31:0] bt, input logic jp,
                         input logic [31:0] jt);
        stall = st; imem_ack = ak; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; imem_rdata = mem(imem_addr);
    endtask

    function automatic logic [31:0] rand_target();
        return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    endfunction

    logic [31:0] model_pc, p_addr, o_instr, o_pc4;
    logic        p_req, p_ack, o_valid;
    int          loads;

    initial begin
        vec[0]  = mk(0, 1, 0, 0, 0, 0,               0, 0,            0, 1, 32'h0, 0);
        vec[1]  = mk(0, 1, 0, 0, 0, 0,               1, 0,            1, 1, 32'h8C01_0004, 4);
        vec[2]  = mk(0, 1, 0, 0, 0, 0,               1, 4,            1, 1, mem(4), 8);
        vec[3]  = mk(1, 1, 0, 0, 0, 0,               1, 8,            1, 1, mem(4), 8);
        vec[4]  = mk(1, 0, 0, 0, 0, 0,               0, 0,            1, 1, mem(4), 8);
        vec[5]  = mk(1, 0, 0, 0, 0, 0,               0, 0,            1, 1, mem(4), 8);
        vec[6]  = mk(0, 0, 0, 0, 0, 0,               0, 0,            1, 1, mem(8), 12);
        vec[7]  = mk(0, 1, 0, 0, 0, 0,               1, 12,           1, 1, mem(12), 16);
        vec[8]  = mk(0, 0, 1, 32'h40, 0, 0,          1, 16,           0, 0, 0, 0);
        vec[9]  = mk(0, 0, 0, 0, 0, 0,               1, 16,           0, 0, 0, 0);
        vec[10] = mk(0, 1, 0, 0, 0, 0,               1, 16,           0, 0, 0, 0);
        vec[11] = mk(0, 1, 0, 0, 0, 0,               1, 32'h40,       1, 1, mem(32'h40), 32'h44);
        vec[12] = mk(0, 1, 1, 32'h40, 1, 32'h100,    1, 32'h44,       0, 0, 0, 0);
        vec[13] = mk(0, 1, 0, 0, 0, 0,               1, 32'h100,      1, 1, mem(32'h100), 32'h104);
        vec[14] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC,   1, 32'h104,      0, 0, 0, 0);
        vec[15] = mk(0, 0, 1, 32'h200, 0, 0,         1, 32'h104,      0, 0, 0, 0);
        vec[16] = mk(0, 1, 0, 0, 1, 32'hFFFF_FFFC,   1, 32'h104,      0, 0, 0, 0);
        vec[17] = mk(0, 1, 0, 0, 0, 0,               1, 32'hFFFF_FFFC, 1, 1, mem(32'hFFFF_FFFC), 0);
        vec[18] = mk(0, 1, 0, 0, 0, 0,               1, 0,            1, 1, mem(0), 4);
        vec[19] = mk(0, 0, 0, 0, 0, 0,               1, 4,            0, 0, 0, 0);
        vec[20] = mk(1, 0, 0, 0, 0, 0,               1, 4,            0, 0, 0, 0);
        vec[21] = mk(1, 1, 0, 0, 0, 0,               1, 4,            0, 0, 0, 0);
        vec[22] = mk(1, 0, 1, 32'h80, 0, 0,          0, 0,            0, 0, 0, 0);
        vec[23] = mk(0, 1, 0, 0, 0, 0,               1, 32'h80,       1, 1, mem(32'h80), 32'h84);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", 32'(if_id_valid), 0);
        check("rst_instr", if_id_instr, 0);
        check("rst_pc4", if_id_pc4, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vec[i].e_req));
            if (vec[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vec[i].e_addr);
            drive(vec[i].st, vec[i].ak, vec[i].br, vec[i].bt, vec[i].jp, vec[i].jt);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vec[i].e_valid));
            if (vec[i].chk) begin
                check($sformatf("v%0d_instr", i), if_id_instr, vec[i].e_instr);
                check($sformatf("v%0d_pc4", i), if_id_pc4, vec[i].e_pc4);
                check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vec[i].e_instr[31:26]));
            end
        end

        rst_n = 1'b0;
        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("midrst_req", 32'(imem_req), 0);
        check("midrst_addr", imem_addr, 0);
        check("midrst_valid", 32'(if_id_valid), 0);
        check("midrst_instr", if_id_instr, 0);
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("postrst_valid", 32'(if_id_valid), 0);
        check("postrst_req", 32'(imem_req), 1);
        check("postrst_addr", imem_addr, 0);
        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("postrst_instr", if_id_instr, 32'h8C01_0004);
        check("postrst_pc4", if_id_pc4, 4);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_pc = 32'h0;
        loads = 0;
        p_req = 1'b0;
        p_ack = 1'b0;
        p_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (p_req && !p_ack) begin
                check("rnd_req_held", 32'(imem_req), 1);
                check("rnd_addr_held", imem_addr, p_addr);
            end
            drive($urandom_range(0, 99) < 30, imem_req && ($urandom_range(0, 99) < 60),
                  $urandom_range(0, 99) < 5, rand_target(), $urandom_range(0, 99) < 3, rand_target());
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            o_instr = if_id_instr; o_pc4 = if_id_pc4; o_valid = if_id_valid;
            @(negedge clk);
            if (jump || branch_taken) begin
                check("rnd_flush_valid", 32'(if_id_valid), 0);
                model_pc = jump ? jump_target : branch_target;
            end else if (stall) begin
                check("rnd_stall_valid", 32'(if_id_valid), 32'(o_valid));
                check("rnd_stall_instr", if_id_instr, o_instr);
                check("rnd_stall_pc4", if_id_pc4, o_pc4);
            end else if (if_id_valid) begin
                check("rnd_pc4", if_id_pc4, model_pc + 32'd4);
                check("rnd_instr", if_id_instr, mem(model_pc));
                check("rnd_opcode", 32'(opcode), 32'(if_id_instr[31:26]));
                model_pc = model_pc + 32'd4;
                loads++;
            end
        end
        n_tests++;
        if (loads < 200) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d loads, expected at least 200", loads);
        end
`ifdef IFETCH_PERF_EN
        check("fetch_count", fetch_count, 32'(loads));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
